// File: rtl/cntr_16.sv
// ---------------------------------------------------------------------------
// cntr_16 : free-running binary up-counter with clock enable
//
// Counts rising clock edges while ce is high and wraps modulo 2^WIDTH.
// A combinational terminal-count flag lets several of these be chained
// by feeding one stage's tc into the next stage's ce.
//
// Parameters
//   WIDTH    counter width in bits (16 is the intended configuration)
//   RST_VAL  value forced onto the counter while rst is high
//
// Ports
//   clk   in   1          rising-edge clock
//   rst   in   1          asynchronous reset, active-high
//   ce    in   1          count enable, active-high, sampled on rising clk
//   out   out  WIDTH      count value, ascending range: out[0] is the MSB
//   tc    out  1          terminal count: (count == all ones) & ce
// ---------------------------------------------------------------------------
module cntr_16 #(
    parameter int unsigned      WIDTH   = 16,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    output logic [0:WIDTH-1] out,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    // Counter state, held in conventional descending order internally.
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_next;
    logic             w_at_max;

    // Natural modulo-2^WIDTH increment: the carry out of the MSB is dropped,
    // so all-ones rolls over to zero with no sticky indication.
    assign w_count_next = r_count + ONE;
    assign w_at_max     = (r_count == ALL_ONES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= RST_VAL;
        end else if (ce) begin
            r_count <= w_count_next;
        end
    end

    // Assignment between differently-ordered ranges is positional
    // (left-most to left-most), so out[0] receives r_count[WIDTH-1], the MSB.
    assign out = r_count;

    // High in the cycle before the wrap edge. Gated by rst so the flag stays
    // low during reset even if RST_VAL were chosen as all ones.
    assign tc = w_at_max & ce & ~rst;

endmodule

// File: tb/tb_cntr_16.sv
// ---------------------------------------------------------------------------
// tb_cntr_16 : directed self-checking bench for cntr_16
//
// Inputs change 1 ns after a rising edge and outputs are sampled at that same
// point, well away from the next active edge. Expected values are hand
// computed from the count of enabled edges applied since the last reset.
// ---------------------------------------------------------------------------
module tb_cntr_16;

    logic        clk;
    logic        rst;
    logic        ce;
    logic [0:15] out;
    logic        tc;

    int checks;
    int errors;

    cntr_16 #(
        .WIDTH  (16),
        .RST_VAL(16'h0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ce (ce),
        .out(out),
        .tc (tc)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- driver tasks ----------------
    // Advance n rising edges, then settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Synchronous-looking reset pulse, ending 1 ns after an edge with ce=0.
    task automatic apply_reset();
        rst = 1'b1;
        ce  = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        ce  = 1'b0;
        #1;
        // Asynchronous: value must be there before any rising edge.
        checks++;
        if (out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_async: out=%h expected=%h", out, 16'h0000);
        end
        #19;
        checks++;
        if (out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_20ns_out: out=%h expected=%h", out, 16'h0000);
        end
        checks++;
        if (tc !== 1'b0) begin
            errors++;
            $display("FAIL reset_20ns_tc: tc=%b expected=0", tc);
        end
        // ce is ignored while rst is active.
        @(posedge clk);
        #1;
        ce = 1'b1;
        step(3);
        checks++;
        if (out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_overrides_ce: out=%h expected=%h", out, 16'h0000);
        end
        checks++;
        if (tc !== 1'b0) begin
            errors++;
            $display("FAIL reset_tc_with_ce: tc=%b expected=0", tc);
        end
    endtask

    // Leaves the counter at 16'h8000 with ce=1.
    task automatic test_count();
        rst = 1'b0;
        ce  = 1'b1;
        // No increment is allowed between release and the next edge.
        #1;
        checks++;
        if (out !== 16'h0000) begin
            errors++;
            $display("FAIL count_release_hold: out=%h expected=%h", out, 16'h0000);
        end
        step(1);
        checks++;
        if (out !== 16'h0001) begin
            errors++;
            $display("FAIL count_first_edge: out=%h expected=%h", out, 16'h0001);
        end
        step(9);
        checks++;
        if (out !== 16'h000A) begin
            errors++;
            $display("FAIL count_10: out=%h expected=%h", out, 16'h000A);
        end
        step(246);
        checks++;
        if (out !== 16'h0100) begin
            errors++;
            $display("FAIL count_256: out=%h expected=%h", out, 16'h0100);
        end
        step(32768 - 256);
        checks++;
        if (out !== 16'h8000) begin
            errors++;
            $display("FAIL count_32768: out=%h expected=%h", out, 16'h8000);
        end
        checks++;
        if (out[0] !== 1'b1) begin
            errors++;
            $display("FAIL count_msb_is_bit0: out[0]=%b expected=1", out[0]);
        end
        checks++;
        if (out[15] !== 1'b0) begin
            errors++;
            $display("FAIL count_lsb_is_bit15: out[15]=%b expected=0", out[15]);
        end
    endtask

    // Continues from 16'h8000: 65535 enabled edges in total reach 16'hFFFF.
    task automatic test_wrap();
        ce = 1'b1;
        step(32767);
        checks++;
        if (out !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_preload: out=%h expected=%h", out, 16'hFFFF);
        end
        checks++;
        if (tc !== 1'b1) begin
            errors++;
            $display("FAIL wrap_tc_high: tc=%b expected=1", tc);
        end
        // tc follows ce combinationally.
        ce = 1'b0;
        #1;
        checks++;
        if (tc !== 1'b0) begin
            errors++;
            $display("FAIL wrap_tc_needs_ce: tc=%b expected=0", tc);
        end
        ce = 1'b1;
        #1;
        step(1);
        checks++;
        if (out !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_to_zero: out=%h expected=%h", out, 16'h0000);
        end
        checks++;
        if (tc !== 1'b0) begin
            errors++;
            $display("FAIL wrap_tc_low: tc=%b expected=0", tc);
        end
        step(1);
        checks++;
        if (out !== 16'h0001) begin
            errors++;
            $display("FAIL wrap_continues: out=%h expected=%h", out, 16'h0001);
        end
    endtask

    task automatic test_hold();
        apply_reset();
        ce = 1'b1;
        step(16'h1234);
        checks++;
        if (out !== 16'h1234) begin
            errors++;
            $display("FAIL hold_preload: out=%h expected=%h", out, 16'h1234);
        end
        ce = 1'b0;
        step(50);
        checks++;
        if (out !== 16'h1234) begin
            errors++;
            $display("FAIL hold_50_edges: out=%h expected=%h", out, 16'h1234);
        end
        checks++;
        if (tc !== 1'b0) begin
            errors++;
            $display("FAIL hold_tc: tc=%b expected=0", tc);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        ce = 1'b1;
        step(16'h00A5);
        checks++;
        if (out !== 16'h00A5) begin
            errors++;
            $display("FAIL arst_preload: out=%h expected=%h", out, 16'h00A5);
        end
        // Now 1 ns after an edge; assert rst mid-period (next edge is 4 ns away).
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out !== 16'h0000) begin
            errors++;
            $display("FAIL arst_between_edges: out=%h expected=%h", out, 16'h0000);
        end
        step(1);
        // Release mid-period with ce still high.
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out !== 16'h0001) begin
            errors++;
            $display("FAIL arst_resume: out=%h expected=%h", out, 16'h0001);
        end
    endtask

    task automatic test_toggle();
        apply_reset();
        for (int i = 0; i < 100; i++) begin
            ce = (i % 2 == 1);
            step(1);
        end
        checks++;
        if (out !== 16'd50) begin
            errors++;
            $display("FAIL toggle_ce_100: out=%h expected=%h", out, 16'd50);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        ce     = 1'b0;
        test_reset();
        test_count();
        test_wrap();
        test_hold();
        test_async_reset();
        test_toggle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
